// File: rtl/audio_pkg.sv
// Shared types and constants for the audio mixer sequencer and its mute ramp.
package audio_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_SCALE  = 2'd2,
        S_OUTPUT = 2'd3
    } mix_state_t;

    localparam logic [7:0] GAIN_UNITY = 8'h80;
    localparam int         LEVEL_MAX  = 256;
    localparam int         LEVEL_W    = 9;

    // True when a gain register index names an existing channel.
    function automatic logic addr_ok(input int unsigned idx, input int unsigned n);
        return idx < n;
    endfunction

endpackage

// File: rtl/mute_ramp.sv
// Click-free mute level: moves RAMP_STEP per frame towards LEVEL_MAX or 0 and clamps.
module mute_ramp
    import audio_pkg::*;
#(
    parameter int RAMP_STEP = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic               enable,
    output logic [LEVEL_W-1:0] level
);

    localparam logic [LEVEL_W:0] C_MAX  = (LEVEL_W + 1)'(LEVEL_MAX);
    localparam logic [LEVEL_W:0] C_STEP = (LEVEL_W + 1)'(RAMP_STEP);

    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W:0]   w_up;
    logic [LEVEL_W-1:0] w_up_clamp;
    logic [LEVEL_W-1:0] w_down_clamp;

    // One spare bit so the upward sum cannot wrap before the clamp sees it.
    assign w_up         = {1'b0, r_level} + C_STEP;
    assign w_up_clamp   = (w_up > C_MAX) ? C_MAX[LEVEL_W-1:0] : w_up[LEVEL_W-1:0];
    assign w_down_clamp = ({1'b0, r_level} >= C_STEP) ? (r_level - C_STEP[LEVEL_W-1:0]) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (step) begin
            r_level <= enable ? w_up_clamp : w_down_clamp;
        end
    end

    assign level = r_level;

endmodule

// File: rtl/audio_mix_sequencer.sv
// Time-multiplexed audio mixer: per frame, snapshot channels, one shared MAC per step tick,
// saturate, apply the mute ramp level and present the result with a one-clock valid pulse.
module audio_mix_sequencer
    import audio_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int W         = 16,
    parameter int GW        = 8,
    parameter int RAMP_STEP = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_3MHz_en,
    input  logic                      clk_12KHz_en,
    input  logic [W-1:0]              ch_sample [NUM_CH],
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic                      sound_enable,
    input  logic                      gain_we,
    input  logic [$clog2(NUM_CH)-1:0] gain_addr,
    input  logic [GW-1:0]             gain_wdata,
    output logic [W-1:0]              out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun,
    output mix_state_t                dbg_state
);

    localparam int CHW  = $clog2(NUM_CH);
    localparam int ACCW = W + GW + CHW;
    localparam int SCW  = W + LEVEL_W;

    mix_state_t         r_state, w_state_nxt;
    logic [GW-1:0]      r_gain      [NUM_CH];
    logic [GW-1:0]      r_snap_gain [NUM_CH];
    logic [W-1:0]       r_snap_sample [NUM_CH];
    logic [NUM_CH-1:0]  r_snap_en;
    logic               r_snap_snd;
    logic [ACCW-1:0]    r_acc;
    logic [CHW-1:0]     r_ch;
    logic [W-1:0]       r_mix;

    logic               w_snap, w_acc_step, w_scale_step, w_out_load, w_last_ch;
    logic [W-1:0]       w_sel_sample;
    logic [W+GW-1:0]    w_prod;
    logic [ACCW-1:0]    w_shift;
    logic [W-1:0]       w_mix_sat;
    logic [LEVEL_W-1:0] w_level;
    logic [SCW-1:0]     w_scaled_full;
    logic [W-1:0]       w_scaled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (clk_12KHz_en)             w_state_nxt = S_ACCUM;
            S_ACCUM:  if (clk_3MHz_en && w_last_ch) w_state_nxt = S_SCALE;
            S_SCALE:  if (clk_3MHz_en)              w_state_nxt = S_OUTPUT;
            S_OUTPUT:                               w_state_nxt = S_IDLE;
            default:                                w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_snap       = (r_state == S_IDLE) && clk_12KHz_en;
        w_acc_step   = (r_state == S_ACCUM) && clk_3MHz_en;
        w_scale_step = (r_state == S_SCALE) && clk_3MHz_en;
        w_out_load   = (r_state == S_OUTPUT);
        busy         = (r_state != S_IDLE);
    end

    assign dbg_state = r_state;
    assign w_last_ch = (r_ch == CHW'(NUM_CH - 1));

    // Live gain registers; the running frame only ever reads its own snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_gain[i] <= GW'(GAIN_UNITY);
        end else if (gain_we && addr_ok(32'(gain_addr), NUM_CH)) begin
            r_gain[gain_addr] <= gain_wdata;
        end
    end

    // Single shared sample x gain multiplier, addressed by the channel counter.
    assign w_sel_sample = r_snap_en[r_ch] ? r_snap_sample[r_ch] : '0;
    assign w_prod       = {{GW{1'b0}}, w_sel_sample} * {{W{1'b0}}, r_snap_gain[r_ch]};

    assign w_shift   = r_acc >> (GW - 1);
    assign w_mix_sat = (|w_shift[ACCW-1:W]) ? '1 : w_shift[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_snap_sample[i] <= '0;
                r_snap_gain[i]   <= GW'(GAIN_UNITY);
            end
            r_snap_en  <= '0;
            r_snap_snd <= 1'b0;
            r_acc      <= '0;
            r_ch       <= '0;
            r_mix      <= '0;
        end else begin
            if (w_snap) begin
                r_snap_sample <= ch_sample;
                r_snap_gain   <= r_gain;
                r_snap_en     <= ch_enable;
                r_snap_snd    <= sound_enable;
                r_acc         <= '0;
                r_ch          <= '0;
            end else if (w_acc_step) begin
                r_acc <= r_acc + ACCW'(w_prod);
                r_ch  <= r_ch + CHW'(1);
            end
            if (w_scale_step) r_mix <= w_mix_sat;
        end
    end

    mute_ramp #(
        .RAMP_STEP (RAMP_STEP)
    ) u_mute_ramp (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (w_scale_step),
        .enable (r_snap_snd),
        .level  (w_level)
    );

    // Level is already updated by the time OUTPUT runs; 256 passes r_mix through exactly.
    assign w_scaled_full = {{LEVEL_W{1'b0}}, r_mix} * {{W{1'b0}}, w_level};
    assign w_scaled      = W'(w_scaled_full >> (LEVEL_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= w_out_load;
            if (w_out_load) out <= w_scaled;
            if (clk_12KHz_en && (r_state != S_IDLE)) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_audio_mix_sequencer.sv
// Self-checking bench for audio_mix_sequencer: frame-level reference model, random step ticks.
module tb_audio_mix_sequencer;
    import audio_pkg::*;

    localparam int NUM_CH    = 4;
    localparam int W         = 16;
    localparam int GW        = 8;
    localparam int RAMP_STEP = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clk_3MHz_en = 1'b0;
    logic             clk_12KHz_en = 1'b0;
    logic [W-1:0]     ch_sample [NUM_CH];
    logic [NUM_CH-1:0] ch_enable;
    logic             sound_enable;
    logic             gain_we;
    logic [1:0]       gain_addr;
    logic [GW-1:0]    gain_wdata;
    logic [W-1:0]     out;
    logic             out_valid, busy, overrun;
    mix_state_t       dbg_state;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp = '0;
    int           m_gain [NUM_CH];
    int           m_level;

    audio_mix_sequencer #(
        .NUM_CH(NUM_CH), .W(W), .GW(GW), .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_3MHz_en(clk_3MHz_en), .clk_12KHz_en(clk_12KHz_en),
        .ch_sample(ch_sample), .ch_enable(ch_enable), .sound_enable(sound_enable),
        .gain_we(gain_we), .gain_addr(gain_addr), .gain_wdata(gain_wdata),
        .out(out), .out_valid(out_valid), .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    // clock / step-tick generation
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            clk_3MHz_en = ($urandom_range(0, 2) == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Frame result from the arithmetic rules: weighted sum, /128, clamp, ramp, *level/256.
    function automatic logic [W-1:0] model_frame();
        longint sum = 0;
        longint mix;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_enable[i]) sum += longint'(ch_sample[i]) * m_gain[i];
        mix = sum / 128;
        if (mix > 65535) mix = 65535;
        if (sound_enable) m_level = (m_level + RAMP_STEP > 256) ? 256 : m_level + RAMP_STEP;
        else              m_level = (m_level < RAMP_STEP) ? 0 : m_level - RAMP_STEP;
        return W'((mix * m_level) / 256);
    endfunction

    task automatic model_reset();
        m_level = 0;
        for (int i = 0; i < NUM_CH; i++) m_gain[i] = 128;
        exp_q.delete();
        last_exp = '0;
    endtask

    // scoreboard: every cycle out either updates with a pulse or holds
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got out_valid=1 expected 0 at %0t", $time);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("out", 32'(out), 32'(last_exp));
                end
            end else begin
                check("out_hold", 32'(out), 32'(last_exp));
            end
        end
    end

    task automatic write_gain(input int a, input int d);
        gain_we    = 1'b1;
        gain_addr  = 2'(a);
        gain_wdata = 8'(d);
        m_gain[a]  = d & 255;
        @(posedge clk);
        #1;
        gain_we = 1'b0;
    endtask

    // Called at posedge+1 with the DUT idle. Optional gain write / extra strobe land on edge N.
    task automatic do_frame(input int gw_cycle = -1, input int gw_addr = 0, input int gw_data = 0,
                            input int ov_cycle = -1, input bit mid_change = 1'b0);
        int n_ticks = 0;
        bit tick_now = 1'b0;
        bit prev_tick = 1'b0;
        bit done = 1'b0;
        exp_q.push_back(model_frame());
        clk_12KHz_en = 1'b1;
        if (gw_cycle == 0) begin
            gain_we = 1'b1; gain_addr = 2'(gw_addr); gain_wdata = 8'(gw_data);
            m_gain[gw_addr] = gw_data & 255;
        end
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk);
            prev_tick = tick_now;
            tick_now  = clk_3MHz_en;
            if (c > 0 && tick_now) n_ticks++;
            #1;
            clk_12KHz_en = (c + 1 == ov_cycle);
            gain_we      = (c + 1 == gw_cycle);
            if (gain_we) begin
                gain_addr = 2'(gw_addr); gain_wdata = 8'(gw_data);
                m_gain[gw_addr] = gw_data & 255;
            end
            if (mid_change && c == 1) begin
                for (int i = 0; i < NUM_CH; i++) ch_sample[i] = 16'($urandom_range(0, 65535));
                ch_enable    = 4'($urandom_range(0, 15));
                sound_enable = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            if (out_valid) begin
                done = 1'b1;
                check("latency_ticks", 32'(n_ticks - int'(tick_now)), 32'(NUM_CH + 1));
                check("scale_tick_before_out", 32'(prev_tick), 32'd1);
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL frame_timeout: got no out_valid expected one within 400 cycles");
        end
        clk_12KHz_en = 1'b0;
        gain_we      = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_samples(input logic [W-1:0] v);
        for (int i = 0; i < NUM_CH; i++) ch_sample[i] = v;
    endtask

    initial begin
        int c;
        set_samples(16'h1000);
        ch_enable    = 4'hF;
        sound_enable = 1'b1;
        gain_we      = 1'b0;
        gain_addr    = '0;
        gain_wdata   = '0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", 32'(out), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ramp up from level 0, then hold
        for (int f = 1; f <= 9; f++) begin
            do_frame();
            if (f == 1) check("ramp_up_f1", 32'(out), 32'h0800);
            if (f == 8) check("ramp_up_f8", 32'(out), 32'h4000);
            if (f == 9) check("steady_mix", 32'(out), 32'h4000);
        end
        sound_enable = 1'b0;
        for (int f = 1; f <= 8; f++) begin
            do_frame();
            if (f == 1) check("ramp_down_f1", 32'(out), 32'h3800);
            if (f == 8) check("ramp_down_f8", 32'(out), 32'h0);
        end
        sound_enable = 1'b1;
        repeat (8) do_frame();
        check("ramp_back_up", 32'(out), 32'h4000);

        set_samples(16'hFFFF);
        for (int i = 0; i < NUM_CH; i++) write_gain(i, 8'hFF);
        do_frame();
        check("saturation", 32'(out), 32'hFFFF);

        set_samples(16'h1000);
        for (int i = 0; i < NUM_CH; i++) write_gain(i, 8'h80);
        do_frame(2, 2, 0);
        check("gain_write_mid_frame_cur", 32'(out), 32'h4000);
        do_frame();
        check("gain_write_mid_frame_next", 32'(out), 32'h3000);
        do_frame(0, 2, 8'h80);
        check("gain_write_at_snapshot", 32'(out), 32'h3000);
        do_frame();
        check("gain_restored", 32'(out), 32'h4000);

        check("overrun_clear", 32'(overrun), 32'h0);
        do_frame(-1, 0, 0, 3);
        check("overrun_frame_out", 32'(out), 32'h4000);
        check("overrun_set", 32'(overrun), 32'h1);
        ch_enable = 4'b0001;
        do_frame();
        check("single_channel", 32'(out), 32'h1000);
        ch_enable = 4'hF;

        // randomized frames
        repeat (25) begin
            for (int i = 0; i < NUM_CH; i++) ch_sample[i] = 16'($urandom_range(0, 65535));
            ch_enable    = 4'($urandom_range(0, 15));
            sound_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) write_gain($urandom_range(0, 3), $urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1)
                do_frame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255),
                         -1, 1'($urandom_range(0, 1)));
            else
                do_frame(-1, 0, 0, -1, 1'($urandom_range(0, 1)));
        end
        check("overrun_sticky", 32'(overrun), 32'h1);

        // reset while in SCALE
        write_gain(1, 8'h40);
        set_samples(16'h1000);
        ch_enable    = 4'hF;
        sound_enable = 1'b1;
        clk_12KHz_en = 1'b1;
        @(posedge clk); #1;
        clk_12KHz_en = 1'b0;
        c = 0;
        while (dbg_state != S_SCALE && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        check("reach_scale", 32'(dbg_state == S_SCALE), 32'h1);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_out", 32'(out), 32'h0);
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_overrun", 32'(overrun), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_frame();
        check("post_reset_frame", 32'(out), 32'h0800);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/audio_mix_sequencer.md
# audio_mix_sequencer

Time-multiplexed mixer controller for the audio output path. Once per 12 kHz sample frame it snapshots all channel samples, steps them one per 3 MHz tick through a single shared gain multiply-accumulate, saturates the sum, and applies a click-free mute ramp driven by `sound_enable`. It sits between the sound sources (filtered POKEY, analog sound) and the audio DAC/output register. Gains are written over a small register port.

## Interface
Parameters:
- `NUM_CH`, 4: number of mixed channels.
- `W`, 16: channel sample and output width, unsigned.
- `GW`, 8: gain width, unsigned; `0x80` = unity.
- `RAMP_STEP`, 32: mute-level change per frame.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clk_3MHz_en` in 1: one-`clk` step strobe.
- `clk_12KHz_en` in 1: one-`clk` frame strobe; may coincide with `clk_3MHz_en`.
- `ch_sample[NUM_CH]` in W each: channel samples.
- `ch_enable` in NUM_CH: per-channel enable; a disabled channel contributes 0.
- `sound_enable` in 1: master enable (output latch bit 5).
- `gain_we` in 1: gain write strobe.
- `gain_addr` in clog2(NUM_CH): gain register index.
- `gain_wdata` in GW: gain value.
- `out` out W: mixed sample.
- `out_valid` out 1: one-`clk` pulse when `out` updates.
- `busy` out 1: high when the state is not IDLE.
- `overrun` out 1: sticky; a frame strobe arrived while busy.

## Operation
- States: IDLE, ACCUM, SCALE, OUTPUT.
- IDLE:
  - On `clk_12KHz_en`: snapshot `ch_sample`, `ch_enable`, all gains and `sound_enable`; set acc=0 and ch=0; go to ACCUM.
- ACCUM:
  - Each `clk_3MHz_en`: acc += en[ch] ? sample[ch]*gain[ch] : 0; ch++.
  - After ch=NUM_CH-1 is processed, go to SCALE.
  - acc width is W+GW+clog2(NUM_CH); acc never wraps.
- SCALE:
  - On `clk_3MHz_en`, update level (0..256, 9 bits) from the snapshotted enable.
    - Enable set: level = min(level+RAMP_STEP, 256).
    - Enable clear: level = max(level−RAMP_STEP, 0).
  - mix = acc >> (GW−1), saturated to 2^W−1.
  - Scaled value = (mix*level) >> 8. Level 256 passes mix exactly; level 0 yields exactly 0.
  - Go to OUTPUT.
- OUTPUT:
  - On the next `clk`, register `out`, pulse `out_valid`, go to IDLE.
- A frame strobe received while not IDLE is dropped, sets `overrun`, and leaves the frame in progress unaffected.
- Gain writes:
  - Take effect at the next clk edge.
  - Are used from the next frame snapshot onward.
  - Never disturb the frame in progress.
  - If `gain_addr` ≥ NUM_CH the write is ignored.
- A gain write coincident with the snapshot edge is not seen by that frame.

## Timing
- Reset values:
  - `out`=0, `out_valid`=0, `busy`=0, `overrun`=0.
  - State IDLE, level=0, acc=0, all gains=`0x80`.
- Frame latency: the strobe edge, then NUM_CH `clk_3MHz_en` ticks, 1 tick for SCALE, then 1 `clk` for OUTPUT. With NUM_CH=4, `out_valid` follows 5 step ticks plus 1 clk.
- A strobe coinciding with `clk_3MHz_en` only snapshots; the first accumulate is on the following tick.
- Between strobes `out` holds its value.
- Reset asserted mid-frame returns immediately to the reset values. `overrun` is cleared only by reset.
- With 250 step ticks per frame there is no overrun in normal operation.

## Structure
- Shared package `audio_pkg`:
  - state enum `mix_state_t`.
  - `GAIN_UNITY`=`8'h80`.
  - `LEVEL_MAX`=256.
  - `LEVEL_W`=9.
- Sub-module `mute_ramp`: level counter with clamp. Its inputs are `rst_n`, `step` (the SCALE tick), the enable and `RAMP_STEP`.
- The sample×gain multiplier and the mix×level multiplier are each instantiated once; the mixer has no per-channel duplication.

## Test plan
- Bench parameters: NUM_CH=4, RAMP_STEP=32.
- Steady mix: level at 256, gains `0x80`, samples `0x1000`, all channels enabled -> `out`=`0x4000` with one `out_valid` per frame.
- Ramp-up after reset: `sound_enable`=1, same stimulus -> frame 1 `out`=`0x0800`, frame 8 `out`=`0x4000` and it holds. Then drop `sound_enable` -> frame 1 after the drop `out`=`0x3800`, frame 8 `out`=0.
- Saturation: samples `0xFFFF`, gains `0xFF`, level 256 -> `out`=`0xFFFF`, no wrap.
- Gain write mid-frame: set gain[2]=`0x00` during ACCUM -> the current frame is still `0x4000`; the next frame is `0x3000`. A write with `gain_addr` ≥ 4 changes nothing.
- Overrun and disable: strobe during ACCUM -> `overrun`=1 and the frame completes normally. `ch_enable`=`4'b0001` -> `out`=`0x1000`.
- Reset mid-frame: `rst_n` low during SCALE -> `out`=0, `busy`=0, level=0, gains `0x80`. After release, the next frame with `sound_enable`=1 gives `0x0800`.
